// File: rtl/goertzel_tone_detector.sv
// Debounced tone decision on a stream of Goertzel magnitudes: on/off hysteresis
// thresholds, run-length debouncing, peak-hold and a saturating result counter.
module goertzel_tone_detector #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ON_COUNT  = 4,
    parameter int unsigned OFF_COUNT = 4
) (
    input  logic              system_clk,
    input  logic              sys_rst_n,
    input  logic              result_valid,
    input  logic [DATA_W-1:0] result_data,
    input  logic [DATA_W-1:0] thresh_on,
    input  logic [DATA_W-1:0] thresh_off,
    input  logic              clear,
    output logic              tone_present,
    output logic              tone_rise,
    output logic              tone_fall,
    output logic [DATA_W-1:0] peak_value,
    output logic [15:0]       result_count
);

    typedef enum logic [1:0] {StAbsent, StArming, StPresent, StReleasing} state_e;

    localparam logic [7:0] OnTarget  = 8'(ON_COUNT);
    localparam logic [7:0] OffTarget = 8'(OFF_COUNT);

    state_e            state_q, state_d;
    logic [7:0]        run_q, run_d;
    logic [7:0]        run_inc;
    logic              hit, miss, accept;
    logic              present_d, rise_d, fall_d;
    logic [DATA_W-1:0] peak_d;
    logic [15:0]       count_d;

    assign hit     = result_data >= thresh_on;
    assign miss    = result_data < thresh_off;
    assign run_inc = run_q + 8'd1;
    // clear discards any simultaneous result
    assign accept  = result_valid && !clear;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (clear) begin
            state_d = StAbsent;
            run_d   = '0;
        end else if (result_valid) begin
            unique case (state_q)
                StAbsent: begin
                    if (hit) begin
                        if (OnTarget <= 8'd1) begin
                            state_d = StPresent;
                        end else begin
                            state_d = StArming;
                            run_d   = 8'd1;
                        end
                    end
                end
                StArming: begin
                    if (hit) begin
                        if (run_inc >= OnTarget) begin
                            state_d = StPresent;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        state_d = StAbsent;
                        run_d   = '0;
                    end
                end
                StPresent: begin
                    if (miss) begin
                        if (OffTarget <= 8'd1) begin
                            state_d = StAbsent;
                        end else begin
                            state_d = StReleasing;
                            run_d   = 8'd1;
                        end
                    end
                end
                StReleasing: begin
                    if (miss) begin
                        if (run_inc >= OffTarget) begin
                            state_d = StAbsent;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        state_d = StPresent;
                        run_d   = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        present_d = (state_d == StPresent) || (state_d == StReleasing);
        rise_d    = (state_d == StPresent) &&
                    ((state_q == StAbsent) || (state_q == StArming));
        fall_d    = (state_d == StAbsent) &&
                    ((state_q == StPresent) || (state_q == StReleasing));
        peak_d    = peak_value;
        count_d   = result_count;
        if (clear) begin
            peak_d  = '0;
            count_d = '0;
        end else if (accept) begin
            if (result_data > peak_value) peak_d = result_data;
            if (result_count != 16'hFFFF) count_d = result_count + 16'd1;
        end
    end

    always_ff @(posedge system_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StAbsent;
            run_q        <= '0;
            tone_present <= 1'b0;
            tone_rise    <= 1'b0;
            tone_fall    <= 1'b0;
            peak_value   <= '0;
            result_count <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            tone_present <= present_d;
            tone_rise    <= rise_d;
            tone_fall    <= fall_d;
            peak_value   <= peak_d;
            result_count <= count_d;
        end
    end

endmodule

// File: tb/tb_goertzel_tone_detector.sv
// Directed and randomized bench for goertzel_tone_detector, checked against a
// run-length model of the tone decision, peak-hold and saturating counter.
module tb_goertzel_tone_detector;

    localparam int DATA_W = 16;
    localparam int ON_N   = 4;
    localparam int OFF_N  = 4;

    logic              system_clk = 1'b0;
    logic              sys_rst_n  = 1'b0;
    logic              result_valid = 1'b0;
    logic [DATA_W-1:0] result_data  = '0;
    logic [DATA_W-1:0] thresh_on    = 16'd1000;
    logic [DATA_W-1:0] thresh_off   = 16'd600;
    logic              clear        = 1'b0;
    logic              tone_present, tone_rise, tone_fall;
    logic [DATA_W-1:0] peak_value;
    logic [15:0]       result_count;

    goertzel_tone_detector #(
        .DATA_W   (DATA_W),
        .ON_COUNT (ON_N),
        .OFF_COUNT(OFF_N)
    ) dut (
        .system_clk  (system_clk),
        .sys_rst_n   (sys_rst_n),
        .result_valid(result_valid),
        .result_data (result_data),
        .thresh_on   (thresh_on),
        .thresh_off  (thresh_off),
        .clear       (clear),
        .tone_present(tone_present),
        .tone_rise   (tone_rise),
        .tone_fall   (tone_fall),
        .peak_value  (peak_value),
        .result_count(result_count)
    );

    always #5 system_clk = ~system_clk;

    int checks = 0;
    int passes = 0;

    // Reference model: tone flips after ON_N consecutive hits / OFF_N consecutive misses
    bit m_tone, m_rise, m_fall;
    int m_hits, m_misses, m_peak, m_count;

    task automatic model_reset();
        m_tone = 0; m_rise = 0; m_fall = 0;
        m_hits = 0; m_misses = 0; m_peak = 0; m_count = 0;
    endtask

    task automatic model_step(input bit valid, input int data, input bit clr);
        m_rise = 0;
        m_fall = 0;
        if (clr) begin
            m_fall = m_tone;
            m_tone = 0; m_hits = 0; m_misses = 0; m_peak = 0; m_count = 0;
        end else if (valid) begin
            if (data > m_peak) m_peak = data;
            if (m_count < 65535) m_count++;
            if (!m_tone) begin
                m_hits = (data >= int'(thresh_on)) ? m_hits + 1 : 0;
                if (m_hits == ON_N) begin
                    m_tone = 1; m_rise = 1; m_hits = 0;
                end
            end else begin
                m_misses = (data < int'(thresh_off)) ? m_misses + 1 : 0;
                if (m_misses == OFF_N) begin
                    m_tone = 0; m_fall = 1; m_misses = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".tone_present"}, int'(tone_present), int'(m_tone));
        check({tag, ".tone_rise"}, int'(tone_rise), int'(m_rise));
        check({tag, ".tone_fall"}, int'(tone_fall), int'(m_fall));
        check({tag, ".peak_value"}, int'(peak_value), m_peak);
        check({tag, ".result_count"}, int'(result_count), m_count);
    endtask

    // Drive at negedge, clock once, update model, check at the following negedge
    task automatic step(input bit valid, input int data, input bit clr, input bit chk,
                        input string tag);
        result_valid = valid;
        result_data  = DATA_W'(data);
        clear        = clr;
        @(posedge system_clk);
        model_step(valid, data, clr);
        @(negedge system_clk);
        result_valid = 1'b0;
        clear        = 1'b0;
        if (chk) check_outputs(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge system_clk);
        check_outputs("reset");
        sys_rst_n = 1'b1;
        @(negedge system_clk);

        // Rise after four hits
        for (int i = 0; i < 4; i++) step(1, 1200, 0, 1, "t1_hit");
        check("t1_present", int'(tone_present), 1);
        step(0, 0, 0, 1, "t1_idle");

        // Hysteresis band then four misses
        step(1, 800, 0, 1, "t2_band");
        step(1, 800, 0, 1, "t2_band");
        for (int i = 0; i < 4; i++) step(1, 500, 0, 1, "t2_miss");
        check("t2_absent", int'(tone_present), 0);

        // Interrupted run restarts
        for (int i = 0; i < 3; i++) step(1, 1200, 0, 1, "t3_hit");
        step(1, 900, 0, 1, "t3_break");
        for (int i = 0; i < 4; i++) step(1, 1200, 0, 1, "t3_rehit");

        // Clear wins over a simultaneous result
        step(1, 2000, 1, 1, "t4_clear");
        check("t4_fall", int'(tone_fall), 1);
        check("t4_peak", int'(peak_value), 0);

        // Counter saturation
        for (int i = 0; i < 65534; i++) step(1, 100, 0, 0, "t5_bulk");
        check("t5_fffe", int'(result_count), 16'hFFFE);
        for (int i = 0; i < 3; i++) step(1, 100, 0, 1, "t5_sat");
        check("t5_ffff", int'(result_count), 16'hFFFF);

        // Async reset mid-arming
        step(1, 0, 1, 1, "t6_clear");
        step(1, 1500, 0, 1, "t6_arm");
        step(1, 1500, 0, 1, "t6_arm");
        #2 sys_rst_n = 1'b0;
        #1 model_reset();
        check_outputs("t6_async");
        #3 sys_rst_n = 1'b1;
        @(negedge system_clk);
        step(1, 1500, 0, 1, "t6_post");
        step(1, 1500, 0, 1, "t6_post");

        // Randomized traffic around the thresholds
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, int'($urandom_range(0, 1600)),
                 ($urandom % 60) == 0, 1, "rand");

        // Inverted thresholds, applied literally
        thresh_on  = 16'd900;
        thresh_off = 16'd1100;
        for (int i = 0; i < 200; i++)
            step(($urandom % 3) != 0, int'($urandom_range(500, 1500)),
                 ($urandom % 80) == 0, 1, "rand_inv");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
